phy_mgmt: RTL
=============

PHY_MGMT -- requirements
Module: phy_mgmt

Interface
REQ-001 SHALL have parameter NUM_PHY, default 1, number of PHYs polled (1..4).
REQ-002 SHALL have parameter PHY_ADDR_BASE, default 0, MDIO address of PHY 0; PHY p uses PHY_ADDR_BASE+p.
REQ-003 SHALL have parameter MDC_DIV, default 5, clk cycles per MDC half-period (>=2).
REQ-004 SHALL have parameter POLL_INTERVAL, default 2500000, idle clk cycles between automatic polls (>=1).
REQ-005 SHALL have port clk  input  1  system clock; single clock domain.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports req_valid input 1 and req_ready output 1: host request handshake.
REQ-008 SHALL have ports req_write input 1, req_phyad input 5, req_regad input 5 and req_wdata input 16: op (1=write), PHY and register address, write data.
REQ-009 SHALL have ports rsp_valid output 1, rsp_rdata output 16 and rsp_err output 1: one-cycle completion pulse, read data, no-PHY flag.
REQ-010 SHALL have ports mdc output 1, mdio_o output 1, mdio_oe output 1 and mdio_i input 1: MDIO pins; the tristate buffer is external.
REQ-011 SHALL have port link_up  output  NUM_PHY  per-PHY link status.

Function
REQ-012 SHALL issue Clause-22 frames: 32 ones preamble, ST=01, OP (10 read, 01 write), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], MSB first; 64 MDC periods per frame.
REQ-013 SHALL use states IDLE -> PRE (32 bits) -> CMD (14 bits) -> TA (2 bits) -> DATA (16 bits) -> DONE -> IDLE.
REQ-014 SHALL hold mdc low in IDLE and toggle it every MDC_DIV clk cycles only during a frame; each frame = 128*MDC_DIV clk cycles from acceptance to DONE.
REQ-015 SHALL update mdio_o on the clk cycle that mdc goes low, and sample mdio_i on the clk cycle that mdc goes high.
REQ-016 SHALL drive mdio_oe=1 for the whole of a write frame; on a read, mdio_oe=1 through CMD, 0 for TA and DATA; write TA drives 1 then 0.
REQ-017 SHALL assert req_ready only in IDLE; a request is accepted on a cycle with req_valid && req_ready, and its fields are latched at acceptance.
REQ-018 SHALL pulse rsp_valid for exactly one cycle in DONE for host-originated frames only; rsp_rdata holds the captured data until the next host completion.
REQ-019 SHALL set rsp_err=1 when the second TA bit of a read samples mdio_i=1; rsp_err SHALL be 0 for writes.
REQ-020 SHALL give a host request priority over a poll that becomes due on the same cycle; the poll SHALL stay pending and run at the next IDLE.
REQ-021 SHALL never interrupt or modify a frame in progress; req_valid during a frame is ignored until IDLE.

Reset
REQ-022 SHALL, on rst=1 at any point including mid-frame, return to IDLE on the next edge with mdc=0, mdio_o=1, mdio_oe=0, req_ready=0 for that cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, link_up=0, poll counter=0, poll index=0.
REQ-023 SHALL assert req_ready on the first cycle after rst deasserts.

Configuration
REQ-024 SHALL, with PHY_MGMT_POLL_EN defined, count POLL_INTERVAL cycles while IDLE, then read register 1 (BMSR) of PHY index p (round-robin 0..NUM_PHY-1, wrapping) and set link_up[p]=rdata[2], or link_up[p]=0 on TA error.
REQ-025 SHALL, without PHY_MGMT_POLL_EN, omit the poll counter and poll sequencer, tie link_up to 0, and issue only host frames.

Verification (MDC_DIV=2, NUM_PHY=2, PHY_ADDR_BASE=1, POLL_INTERVAL=50)
REQ-026 SHALL verify a write: req phyad=1, regad=0, wdata=0x1140 -> the serial bitstream equals 32 ones then 0101_00001_00000_10_0001000101000000; rsp_valid pulses 256 cycles after acceptance with rsp_err=0.
REQ-027 SHALL verify a read: the PHY model returns 0x796D for regad=2 -> rsp_rdata=0x796D, rsp_err=0, and mdio_oe=0 for exactly the last 18 MDC periods.
REQ-028 SHALL verify no PHY: mdio_i held 1 during a read -> rsp_err=1 and rsp_rdata=0xFFFF.
REQ-029 SHALL verify polling (macro on): PHY addr 1 BMSR=0x0004 and addr 2 BMSR=0x0000 -> link_up=2'b01 after two polls, with no rsp_valid pulses.
REQ-030 SHALL verify collision and reset: req_valid on the cycle a poll becomes due -> the host frame runs first; rst asserted at frame bit 40 -> mdc=0 and mdio_oe=0 on the next cycle, with no rsp_valid.

Source files
------------

// File: rtl/phy_mgmt.sv
// Clause-22 MDIO management master: host read/write frames, plus optional
// round-robin BMSR link polling when PHY_MGMT_POLL_EN is defined.
module phy_mgmt #(
  parameter int NUM_PHY       = 1,
  parameter int PHY_ADDR_BASE = 0,
  parameter int MDC_DIV       = 5,
  parameter int POLL_INTERVAL = 2500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [4:0]         req_phyad,
  input  logic [4:0]         req_regad,
  input  logic [15:0]        req_wdata,
  output logic               rsp_valid,
  output logic [15:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               mdc,
  output logic               mdio_o,
  output logic               mdio_oe,
  input  logic               mdio_i,
  output logic [NUM_PHY-1:0] link_up
);

  localparam int DIV_W = $clog2(MDC_DIV);

  if (MDC_DIV < 2 || POLL_INTERVAL < 1 || NUM_PHY < 1 || NUM_PHY > 4) begin : g_bad_cfg
    $error("phy_mgmt: unsupported parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_TA, S_DATA, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [62:0]      tx_sr;
  logic [15:0]      rd_sr;
  logic             ta_err, is_write, is_poll, rst_q;
  logic             in_frame, half_end, mdc_fall, mdc_rise, frame_end;
  logic             accept, start, poll_start;
  logic [4:0]       poll_phyad;
  logic             f_write;
  logic [4:0]       f_phyad, f_regad;
  logic [63:0]      frame;

  assign in_frame  = (state == S_PRE) || (state == S_CMD) || (state == S_TA) || (state == S_DATA);
  assign half_end  = in_frame && (div_cnt == DIV_W'(MDC_DIV - 1));
  assign mdc_fall  = half_end && mdc;
  assign mdc_rise  = half_end && !mdc;
  assign frame_end = mdc_fall && (bit_cnt == 6'd63);
  assign accept    = req_valid && req_ready;
  assign start     = accept || poll_start;

  // Undriven read TA/DATA positions are filled with 1 so mdio_o idles high.
  always_comb begin
    f_write = accept ? req_write : 1'b0;
    f_phyad = accept ? req_phyad : poll_phyad;
    f_regad = accept ? req_regad : 5'd1;
    frame   = {32'hFFFF_FFFF, 2'b01, f_write ? 2'b01 : 2'b10, f_phyad, f_regad,
               f_write ? 2'b10 : 2'b11, f_write ? req_wdata : 16'hFFFF};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_PRE;
      S_PRE:  if (mdc_fall && bit_cnt == 6'd31) state_nxt = S_CMD;
      S_CMD:  if (mdc_fall && bit_cnt == 6'd45) state_nxt = S_TA;
      S_TA:   if (mdc_fall && bit_cnt == 6'd47) state_nxt = S_DATA;
      S_DATA: if (frame_end) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE) && !rst_q;
    rsp_valid = (state == S_DONE) && !is_poll;
    mdio_oe   = (state == S_PRE) || (state == S_CMD) ||
                (is_write && ((state == S_TA) || (state == S_DATA)));
  end

  // Bit timing: shift out on the falling mdc edge, sample on the rising one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q     <= 1'b1;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      is_poll   <= 1'b0;
      is_write  <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      if (start) begin
        tx_sr    <= frame[62:0];
        mdio_o   <= frame[63];
        mdc      <= 1'b0;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        is_write <= f_write;
        is_poll  <= poll_start;
      end else if (half_end) begin
        div_cnt <= '0;
        mdc     <= !mdc;
        if (mdc_fall) begin
          bit_cnt <= bit_cnt + 6'd1;
          mdio_o  <= tx_sr[62];
          tx_sr   <= {tx_sr[61:0], 1'b1};
        end
        if (mdc_rise && bit_cnt == 6'd47) ta_err <= mdio_i;
        if (mdc_rise && bit_cnt >= 6'd48) rd_sr <= {rd_sr[14:0], mdio_i};
      end else if (in_frame) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (frame_end && !is_poll) begin
        rsp_err <= is_write ? 1'b0 : ta_err;
        if (!is_write) rsp_rdata <= rd_sr;
      end
    end
  end

`ifdef PHY_MGMT_POLL_EN
  localparam int CNT_W = $clog2(POLL_INTERVAL + 1);
  localparam int IDX_W = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;

  logic [CNT_W-1:0] poll_cnt;
  logic [IDX_W-1:0] poll_idx;
  logic             poll_pend;

  // A due poll waits in poll_pend so a same-cycle host request goes first.
  assign poll_start = (state == S_IDLE) && poll_pend && !accept;
  assign poll_phyad = 5'(PHY_ADDR_BASE + int'(poll_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt  <= '0;
      poll_idx  <= '0;
      poll_pend <= 1'b0;
      link_up   <= '0;
    end else begin
      if (state == S_IDLE && !poll_pend) begin
        if (poll_cnt == CNT_W'(POLL_INTERVAL - 1)) begin
          poll_pend <= 1'b1;
          poll_cnt  <= '0;
        end else begin
          poll_cnt <= poll_cnt + CNT_W'(1);
        end
      end
      if (poll_start) poll_pend <= 1'b0;
      if (state == S_DONE && is_poll) begin
        for (int p = 0; p < NUM_PHY; p++)
          if (poll_idx == IDX_W'(p)) link_up[p] <= !ta_err && rd_sr[2];
        poll_idx <= (poll_idx == IDX_W'(NUM_PHY - 1)) ? '0 : poll_idx + IDX_W'(1);
      end
    end
  end
`else
  assign poll_start = 1'b0;
  assign poll_phyad = 5'(PHY_ADDR_BASE);
  assign link_up    = '0;
`endif

endmodule
